// File: rtl/fetch_pkg.sv
// Shared types and default widths for the instruction fetch sequencer.
package fetch_pkg;

  localparam int unsigned FETCH_ADDR_W     = 12;
  localparam int unsigned FETCH_DATA_W     = 32;
  localparam int unsigned FETCH_FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [FETCH_ADDR_W-1:0] pc;
    logic [FETCH_DATA_W-1:0] data;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Show-ahead synchronous FIFO of fetch entries with flush; head is valid whenever not empty.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH   = FETCH_FIFO_DEPTH,
  parameter type         entry_t = fetch_entry_t
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  entry_t                     entry_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  output entry_t                     head_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  entry_t             mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_q;
  logic [PTR_W-1:0]   rd_q;
  logic [PTR_W:0]     cnt_q;
  logic               full;
  logic               do_push;
  logic               do_pop;

  assign empty_o = (cnt_q == '0);
  assign full    = (cnt_q == (PTR_W+1)'(DEPTH));
  assign do_pop  = pop_i & ~empty_o;
  // A push into a full FIFO is only accepted when the head leaves in the same cycle.
  assign do_push = push_i & (~full | do_pop);
  assign head_o  = mem_q[rd_q];
  assign count_o = cnt_q;

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + PTR_W'(1);
      if (do_pop)  rd_q <= rd_q + PTR_W'(1);
      unique case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + (PTR_W+1)'(1);
        2'b01:   cnt_q <= cnt_q - (PTR_W+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_q] <= entry_i;
  end

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch sequencer: walks the ROM from start_pc to end_pc, absorbs the
// one-cycle ROM latency and hands {pc, instruction} to the decoder via valid/ready.
module inst_fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W     = FETCH_ADDR_W,
  parameter int unsigned DATA_W     = FETCH_DATA_W,
  parameter int unsigned FIFO_DEPTH = FETCH_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_pc,
  input  logic [ADDR_W-1:0] end_pc,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              rom_ce,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_rdata,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [DATA_W-1:0] inst_data,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              busy
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] data;
  } entry_t;

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] end_q, end_d;
  logic              inflight_q;
  logic [ADDR_W-1:0] inflight_pc_q;
  logic              kill_q;

  logic              start_fire;
  logic              redirect_fire;
  logic              credit_ok;
  logic              push;
  logic              pop;
  logic              drain_done;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  entry_t            fifo_head;
  entry_t            fifo_in;

  assign start_fire    = start & (state_q == IDLE);
  assign redirect_fire = redirect_valid & (state_q != IDLE);

  // Reserve a slot for the word already on its way so the FIFO can never overflow.
  assign credit_ok = ({1'b0, fifo_count} + (CNT_W+1)'(inflight_q)) < (CNT_W+1)'(FIFO_DEPTH);

  assign rom_ce   = (state_q == FETCH) & credit_ok;
  assign rom_addr = pc_q;

  // Words issued before a redirect are dropped on arrival: kill_q covers a read
  // issued in the redirect cycle, redirect_fire covers the one landing in it.
  assign push    = inflight_q & ~kill_q & ~redirect_fire;
  assign fifo_in = '{pc: inflight_pc_q, data: rom_rdata};
  assign pop     = inst_valid & inst_ready;

  assign drain_done = ~push & (fifo_count == CNT_W'(pop));

  fetch_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .entry_i (fifo_in),
    .pop_i   (pop),
    .flush_i (redirect_fire),
    .head_o  (fifo_head),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign inst_valid = ~fifo_empty;
  assign inst_pc    = fifo_empty ? '0 : fifo_head.pc;
  assign inst_data  = fifo_empty ? '0 : fifo_head.data;
  assign busy       = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    end_d   = end_q;
    unique case (state_q)
      IDLE: begin
        if (start_fire) begin
          state_d = FETCH;
          pc_d    = start_pc;
          end_d   = end_pc;
        end
      end
      FETCH: begin
        if (redirect_fire) begin
          pc_d = redirect_pc;
        end else if (rom_ce) begin
          pc_d = pc_q + ADDR_W'(1);
          if (pc_q == end_q) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (redirect_fire) begin
          state_d = FETCH;
          pc_d    = redirect_pc;
        end else if (drain_done) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      pc_q          <= '0;
      end_q         <= '0;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      kill_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      end_q         <= end_d;
      inflight_q    <= rom_ce;
      inflight_pc_q <= pc_q;
      kill_q        <= rom_ce & redirect_fire;
    end
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Scoreboard bench for inst_fetch_unit: a ROM model answers reads, an address-list
// model predicts the delivered words, and a negedge monitor checks every handshake.
module tb_inst_fetch_unit;

  localparam int AW = 12;
  localparam int DW = 32;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] start_pc;
  logic [AW-1:0] end_pc;
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;
  logic          rom_ce;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_rdata;
  logic          inst_valid;
  logic          inst_ready;
  logic [DW-1:0] inst_data;
  logic [AW-1:0] inst_pc;
  logic          busy;

  always #5 clk = ~clk;

  inst_fetch_unit #(
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .start_pc       (start_pc),
    .end_pc         (end_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .rom_ce         (rom_ce),
    .rom_addr       (rom_addr),
    .rom_rdata      (rom_rdata),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .busy           (busy)
  );

  int checks = 0;
  int errors = 0;

  logic [AW-1:0] exp_q[$];
  logic [AW-1:0] model_end = '0;

  function automatic logic [DW-1:0] rom_fn(input logic [AW-1:0] a);
    return {4'hC, a, ~a, 4'h5};
  endfunction

  // Registered ROM: data for an address read in cycle N is on rom_rdata in N+1.
  always @(posedge clk) begin
    if (rom_ce) rom_rdata <= rom_fn(rom_addr);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_seq(input logic [AW-1:0] s, input logic [AW-1:0] e);
    logic [AW-1:0] a;
    a = s;
    forever begin
      exp_q.push_back(a);
      if (a == e) break;
      a = a + AW'(1);
    end
  endtask

  // Monitor / scoreboard
  logic          busy_pre;
  logic [AW-1:0] exp_pc;
  logic          prev_stall = 1'b0;
  logic [AW-1:0] prev_pc;
  logic [DW-1:0] prev_data;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      busy_pre = (exp_q.size() > 0);
      check("busy", 64'(busy), 64'(busy_pre));
      if (prev_stall) begin
        check("stall_valid", 64'(inst_valid), 64'(1'b1));
        check("stall_pc", 64'(inst_pc), 64'(prev_pc));
        check("stall_data", 64'(inst_data), 64'(prev_data));
      end
      if (inst_valid && inst_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word actual_pc=%0h required=none at %0t", inst_pc, $time);
        end else begin
          exp_pc = exp_q.pop_front();
          check("inst_pc", 64'(inst_pc), 64'(exp_pc));
          check("inst_data", 64'(inst_data), 64'(rom_fn(exp_pc)));
        end
      end
      prev_stall = inst_valid && !inst_ready && !(redirect_valid && busy_pre);
      prev_pc    = inst_pc;
      prev_data  = inst_data;
      if (start && !busy_pre) begin
        model_end = end_pc;
        push_seq(start_pc, end_pc);
      end
      if (redirect_valid && busy_pre) begin
        exp_q.delete();
        push_seq(redirect_pc, model_end);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [AW-1:0] s, input logic [AW-1:0] e);
    start_pc = s;
    end_pc   = e;
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  task automatic do_redirect(input logic [AW-1:0] t);
    redirect_pc    = t;
    redirect_valid = 1'b1;
    tick();
    redirect_valid = 1'b0;
  endtask

  task automatic wait_idle(input int pct, input int bound);
    int n;
    n = 0;
    while ((busy || exp_q.size() > 0) && n < bound) begin
      inst_ready = ($urandom_range(0, 99) < pct);
      tick();
      n++;
    end
    inst_ready = 1'b1;
    checks++;
    if (n >= bound) begin
      errors++;
      $display("FAIL idle_timeout actual=%0d cycles required<%0d", n, bound);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rom_ce"}, 64'(rom_ce), 64'(1'b0));
    check({tag, "_rom_addr"}, 64'(rom_addr), 64'(0));
    check({tag, "_inst_valid"}, 64'(inst_valid), 64'(1'b0));
    check({tag, "_inst_data"}, 64'(inst_data), 64'(0));
    check({tag, "_inst_pc"}, 64'(inst_pc), 64'(0));
    check({tag, "_busy"}, 64'(busy), 64'(1'b0));
  endtask

  initial begin
    logic [AW-1:0] s, e, t;
    int n, redirs;

    rst = 1'b1; start = 1'b0; start_pc = '0; end_pc = '0;
    redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_reset_outputs("reset");

    // Short run at full rate: first word two cycles after the start edge, then one per cycle.
    do_start(12'h010, 12'h013);
    tick();
    tick();
    for (int unsigned k = 0; k < 4; k++) begin
      check("t1_valid", 64'(inst_valid), 64'(1'b1));
      check("t1_pc", 64'(inst_pc), 64'(12'h010 + 12'(k)));
      tick();
    end
    wait_idle(100, 50);

    // Decoder stall: fetching must stop once the buffer is committed.
    do_start(12'h100, 12'h11F);
    repeat (6) tick();
    inst_ready = 1'b0;
    repeat (10) tick();
    check("t2_rom_ce_stalled", 64'(rom_ce), 64'(1'b0));
    check("t2_valid_stalled", 64'(inst_valid), 64'(1'b1));
    wait_idle(100, 200);

    // Wrap through the top of the address space.
    do_start(12'hFFE, 12'h001);
    wait_idle(100, 50);

    // Redirect with three words buffered and one in flight.
    inst_ready = 1'b0;
    do_start(12'h300, 12'h3FF);
    repeat (4) tick();
    check("t4_rom_ce_full", 64'(rom_ce), 64'(1'b0));
    check("t4_valid_full", 64'(inst_valid), 64'(1'b1));
    do_redirect(12'h200);
    check("t4_valid_after_redirect", 64'(inst_valid), 64'(1'b0));
    tick();
    tick();
    check("t4_valid_target", 64'(inst_valid), 64'(1'b1));
    check("t4_pc_target", 64'(inst_pc), 64'(12'h200));
    wait_idle(70, 2000);

    // Single-word program; a start while busy must be ignored.
    do_start(12'h055, 12'h055);
    do_start(12'h077, 12'h080);
    wait_idle(100, 50);

    // Reset in the middle of a fetch.
    do_start(12'h400, 12'h4FF);
    repeat (6) begin
      inst_ready = $urandom_range(0, 1) == 1;
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    inst_ready = 1'b1;
    check_reset_outputs("midrst");
    tick();
    tick();
    check("midrst_no_stale_word", 64'(inst_valid), 64'(1'b0));
    do_start(12'h020, 12'h025);
    wait_idle(100, 50);

    // Randomized programs with random back-pressure, redirects and stray starts.
    for (int unsigned iter = 0; iter < 25; iter++) begin
      s = 12'($urandom_range(0, 4095));
      e = s + 12'($urandom_range(0, 40));
      do_start(s, e);
      n = 0;
      redirs = 0;
      while ((busy || exp_q.size() > 0) && n < 3000) begin
        inst_ready = ($urandom_range(0, 99) < 70);
        if (redirs < 3 && $urandom_range(0, 24) == 0) begin
          t = e - 12'($urandom_range(0, 20));
          redirect_pc = t;
          redirect_valid = 1'b1;
          redirs++;
        end
        if ($urandom_range(0, 19) == 0) begin
          start_pc = 12'($urandom_range(0, 4095));
          end_pc   = 12'($urandom_range(0, 4095));
          start    = 1'b1;
        end
        tick();
        redirect_valid = 1'b0;
        start = 1'b0;
        n++;
      end
      inst_ready = 1'b1;
      checks++;
      if (n >= 3000) begin
        errors++;
        $display("FAIL rand_timeout actual=%0d cycles required<3000", n);
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
